cordic_vectoring: RTL
=====================

// Module: cordic_vectoring
// PURPOSE
//   Iterative vectoring-mode CORDIC: the inverse of the rotation-mode iteration stage.
//   Drives y to zero to convert a Cartesian vector (x,y) into magnitude and angle,
//   i.e. atan2(y,x).
//   One shared datapath is reused for N_ITERATIONS cycles per sample, under an FSM.
//   Sits beside cordic_top; uses the same fixed-point word and a valid/ready stream on each side.
// PARAMETERS
//   WORD_LENGTH   21  signed I/O word width, Q4.16 (1 sign, 4 int, FRAC_BITS frac)
//   FRAC_BITS     16  fractional bits; the atan ROM constants are fixed for 16
//   N_ITERATIONS  17  micro-rotations per sample, legal range 1..17
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-low reset
//   x_i        in   WORD_LENGTH  signed x input, Q4.16
//   y_i        in   WORD_LENGTH  signed y input, Q4.16
//   in_valid   in   1            x_i/y_i valid
//   in_ready   out  1            block can accept a sample
//   mag_o      out  WORD_LENGTH  signed magnitude, Q4.16, always >= 0
//   angle_o    out  WORD_LENGTH  signed angle in radians, Q4.16, range [-pi,+pi]
//   out_valid  out  1            mag_o/angle_o valid
//   out_ready  in   1            downstream accepts result
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, mag_o=0, angle_o=0, out_valid=0, iteration counter=0.
//     in_ready=1 once reset is released.
//   - FSM IDLE -> ITER -> [SCALE] -> DONE -> IDLE. in_ready = (state==IDLE). No overlap of samples.
//   - Accept edge (IDLE, in_valid=1): load registers with pre-rotated values; go to ITER, i=0.
//     - x_i>=0: x=x_i, y=y_i, z=0.
//     - x_i<0 : x=-x_i, y=-y_i, z = y_i>=0 ? +PI : -PI. PI = 205887.
//   - Datapath width: WORD_LENGTH+2 internal bits (guard bits).
//     - Negating -2^20 does not wrap.
//     - Growth by K=1.64676 does not wrap.
//   - ITER, each edge, with arithmetic shift (>>>) by i:
//     - y>=0: x += y>>>i; y -= x>>>i; z += ATAN[i].
//     - y<0 : x -= y>>>i; y += x>>>i; z -= ATAN[i].
//     - Both updates use the pre-edge x and y. Then i++.
//   - ATAN[i] = round(atan(2^-i)*2^16): 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128,
//     64, 32, 16, 8, 4, 2, 1.
//   - After the N_ITERATIONS-th ITER edge: register mag_o and angle_o, set out_valid=1, go to DONE.
//     - Latency: out_valid rises N_ITERATIONS edges after the accept edge.
//   - mag_o saturates to 2^(WORD_LENGTH-1)-1 if the internal x exceeds the output range.
//     angle_o never saturates.
//   - Zero vector (x_i=y_i=0): mag_o=0, angle_o=0. Same latency as any other sample.
//   - DONE: mag_o/angle_o/out_valid held stable while out_ready=0.
//     - Edge with out_ready=1: out_valid=0, go to IDLE.
//     - in_ready=1 the following cycle. Max throughput is 1 sample per N_ITERATIONS+2 cycles.
//   - in_valid while not IDLE is ignored; x_i/y_i are sampled only on the accept edge.
//   - Reset asserted mid-operation: sample discarded immediately, all outputs to reset values.
// CONFIGURATION
//   - GAIN_COMP_EN defined: adds state SCALE (1 extra cycle).
//     - mag_o = (x * 39797) >>> 16, i.e. x/K, rounded toward zero, then saturated.
//     - Latency becomes N_ITERATIONS+1.
//   - GAIN_COMP_EN undefined: no multiplier.
//     - mag_o is the raw CORDIC magnitude (true magnitude * K).
//     - Latency N_ITERATIONS.
// TESTING  (default params; tolerance +/-8 LSB on mag_o and angle_o)
//   - (x=65536, y=0) -> angle_o=0. mag_o=107925 (raw) / 65536 (GAIN_COMP_EN).
//     out_valid exactly 17 (or 18) edges after accept.
//   - (0, 65536) -> angle_o=102944 (pi/2). (65536, 65536) -> angle_o=51472.
//     mag_o=152628 raw / 92682 with GAIN_COMP_EN.
//   - (-65536, 0) -> angle_o=+205887. (-65536, -1) -> angle_o ~ -205887.
//     (0, -65536) -> angle_o=-102944.
//   - (0, 0) -> mag_o=0, angle_o=0. (-1048576, 0) -> mag_o saturates to 1048575 raw; no wrap.
//   - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0,
//     new in_valid ignored. Release: one handshake, then in_ready=1 next cycle.
//   - Assert rst mid-ITER (i=8): out_valid=0, mag_o=angle_o=0 immediately.
//     After release, next sample (65536, 65536) gives correct results.

Source files
------------

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC. Converts (x,y) to magnitude and
// atan2(y,x) by driving y to zero with one shared datapath reused for N_ITERATIONS cycles.
// Optional feature macro GAIN_COMP_EN: adds a SCALE cycle that divides the magnitude by K.
module cordic_vectoring #(
   parameter int unsigned WORD_LENGTH  = 21,
   parameter int unsigned FRAC_BITS    = 16,
   parameter int unsigned N_ITERATIONS = 17
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [WORD_LENGTH-1:0] x_i,
   input  logic signed [WORD_LENGTH-1:0] y_i,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic signed [WORD_LENGTH-1:0] mag_o,
   output logic signed [WORD_LENGTH-1:0] angle_o,
   output logic                          out_valid,
   input  logic                          out_ready
);

   // Two guard bits: -min negation and K growth of a diagonal full-scale vector both fit.
   localparam int unsigned IW        = WORD_LENGTH + 2;
   localparam int unsigned CNT_W     = 5;
   // ROM constants are stored with 16 fractional bits; narrower formats (<=16) truncate them.
   localparam int unsigned ROM_FRAC  = 16;
   localparam int unsigned ROM_SHIFT = ROM_FRAC - FRAC_BITS;
   localparam logic signed [IW-1:0] PI_Q    = IW'(205887 >> ROM_SHIFT);
   localparam logic signed [IW-1:0] MAG_MAX = IW'((1 << (WORD_LENGTH - 1)) - 1);
   localparam logic [CNT_W-1:0]     LAST    = CNT_W'(N_ITERATIONS - 1);
`ifdef GAIN_COMP_EN
   localparam int unsigned PW = IW + 17;
   localparam logic signed [PW-1:0] INV_K = PW'(39797);
`endif

`ifdef GAIN_COMP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, SCALE = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t                        state, state_nxt;
   logic signed [IW-1:0]          x_q, y_q, z_q, x_nxt, y_nxt, z_nxt;
   logic signed [IW-1:0]          x_sh, y_sh, x_rot, y_rot, z_rot, x_ext, y_ext;
   logic [CNT_W-1:0]              cnt_q, cnt_nxt;
   logic                          zero_q, zero_nxt;
   logic signed [WORD_LENGTH-1:0] mag_nxt, ang_nxt;
   logic                          out_valid_nxt, in_ready_nxt;
`ifdef GAIN_COMP_EN
   logic signed [PW-1:0]          prod;
   logic signed [IW-1:0]          scaled;
`endif

   // atan(2^-i) table in radians
   function automatic logic signed [IW-1:0] atan_rom(input logic [CNT_W-1:0] idx);
      int unsigned v;
      case (idx)
         5'd0:    v = 51472;
         5'd1:    v = 30386;
         5'd2:    v = 16055;
         5'd3:    v = 8150;
         5'd4:    v = 4091;
         5'd5:    v = 2047;
         5'd6:    v = 1024;
         5'd7:    v = 512;
         5'd8:    v = 256;
         5'd9:    v = 128;
         5'd10:   v = 64;
         5'd11:   v = 32;
         5'd12:   v = 16;
         5'd13:   v = 8;
         5'd14:   v = 4;
         5'd15:   v = 2;
         5'd16:   v = 1;
         default: v = 0;
      endcase
      return IW'(v >> ROM_SHIFT);
   endfunction

   // Clamp the internal magnitude into the non-negative output range
   function automatic logic signed [WORD_LENGTH-1:0] sat_mag(input logic signed [IW-1:0] v);
      if (v[IW-1])
         return '0;
      if (v > MAG_MAX)
         return MAG_MAX[WORD_LENGTH-1:0];
      return v[WORD_LENGTH-1:0];
   endfunction

   // Next-state, datapath and output logic
   always_comb begin
      state_nxt     = state;
      x_nxt         = x_q;
      y_nxt         = y_q;
      z_nxt         = z_q;
      cnt_nxt       = cnt_q;
      zero_nxt      = zero_q;
      mag_nxt       = mag_o;
      ang_nxt       = angle_o;
      out_valid_nxt = out_valid;

      x_ext = {{2{x_i[WORD_LENGTH-1]}}, x_i};
      y_ext = {{2{y_i[WORD_LENGTH-1]}}, y_i};
      x_sh  = x_q >>> cnt_q;
      y_sh  = y_q >>> cnt_q;
      if (!y_q[IW-1]) begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_rom(cnt_q);
      end else begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_rom(cnt_q);
      end
`ifdef GAIN_COMP_EN
      prod   = PW'(x_q) * INV_K;
      scaled = IW'(prod >>> ROM_FRAC);
`endif

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = ITER;
               cnt_nxt   = '0;
               zero_nxt  = (x_i == '0) && (y_i == '0);
               // Left half-plane: rotate by pi so iterations only cover +/- pi/2
               if (!x_i[WORD_LENGTH-1]) begin
                  x_nxt = x_ext;
                  y_nxt = y_ext;
                  z_nxt = '0;
               end else begin
                  x_nxt = -x_ext;
                  y_nxt = -y_ext;
                  z_nxt = y_i[WORD_LENGTH-1] ? -PI_Q : PI_Q;
               end
            end
         end
         ITER: begin
            x_nxt   = x_rot;
            y_nxt   = y_rot;
            z_nxt   = z_rot;
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
`ifdef GAIN_COMP_EN
               state_nxt = SCALE;
`else
               state_nxt     = DONE;
               mag_nxt       = sat_mag(x_rot);
               ang_nxt       = zero_q ? '0 : WORD_LENGTH'(z_rot);
               out_valid_nxt = 1'b1;
`endif
            end
         end
`ifdef GAIN_COMP_EN
         SCALE: begin
            state_nxt     = DONE;
            mag_nxt       = sat_mag(scaled);
            ang_nxt       = zero_q ? '0 : WORD_LENGTH'(z_q);
            out_valid_nxt = 1'b1;
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_nxt     = IDLE;
               out_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      in_ready_nxt = (state_nxt == IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         cnt_q     <= '0;
         zero_q    <= 1'b0;
         mag_o     <= '0;
         angle_o   <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_nxt;
         x_q       <= x_nxt;
         y_q       <= y_nxt;
         z_q       <= z_nxt;
         cnt_q     <= cnt_nxt;
         zero_q    <= zero_nxt;
         mag_o     <= mag_nxt;
         angle_o   <= ang_nxt;
         out_valid <= out_valid_nxt;
         in_ready  <= in_ready_nxt;
      end
   end

endmodule
